mu0_uart_tx: RTL

Memory-mapped serial transmitter on the MU0 data bus, alongside MU0_Memory, downstream of the CPU's write port. It snoops `Addr`/`Dout`/`Wr` from MU0, buffers bytes in a small FIFO and shifts them out as 8N1 frames on `Tx`. It also returns a status word that the top-level read mux routes to MU0's `Din` when `Sel` is high.

---
 rtl/mu0_uart_tx.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mu0_uart_tx.sv
// -----------------------------------------------------------------------------
// mu0_uart_tx
//
// Memory-mapped serial transmitter for the MU0 data bus. It snoops the CPU
// write port, queues bytes written to the DATA register in a small FIFO and
// shifts them out LSB first as 8N1 frames on Tx. It also returns a status word
// for the top-level read mux.
//
// Register window (BASE_ADDR must be even):
//   BASE_ADDR+0  DATA    write-only; a write pushes Dout[7:0]
//   BASE_ADDR+1  STATUS  read : {13'b0, overflow, busy, full}
//                        write: any value clears overflow
//
// Parameters:
//   BASE_ADDR   base of the two-word register window
//   BAUD_DIV    clock cycles per serial bit (>= 2)
//   FIFO_DEPTH  FIFO entries (power of two, >= 2)
//
// Ports:
//   Clk      in   system clock, rising edge
//   Reset    in   synchronous, active-low reset
//   Addr     in   [11:0] MU0 address bus
//   Dout     in   [15:0] MU0 write data
//   Wr       in   MU0 write strobe
//   Sel      out  high when Addr selects STATUS (combinational)
//   Rd_data  out  [15:0] status word (combinational)
//   Tx       out  serial line, idle high, registered
//   Busy     out  frame in progress or bytes still queued
//
// Build option:
//   MU0_UART_TX_PARITY_EN  when defined, an even-parity bit is sent between
//                          the last data bit and the stop bit (11-bit frames).
// -----------------------------------------------------------------------------
module mu0_uart_tx #(
  parameter logic [11:0] BASE_ADDR  = 12'hFF0,
  parameter int          BAUD_DIV   = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] Addr,
  input  logic [15:0] Dout,
  input  logic        Wr,
  output logic        Sel,
  output logic [15:0] Rd_data,
  output logic        Tx,
  output logic        Busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

`ifdef MU0_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic w_data_wr;
  logic w_stat_wr;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_unused;

  assign w_data_wr = Wr && (Addr == BASE_ADDR);
  assign w_stat_wr = Wr && (Addr == BASE_ADDR + 12'd1);
  assign w_unused  = ^Dout[15:8];

  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit so full and empty are distinct.
  // ---------------------------------------------------------------------------
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_overflow;
  logic [7:0]  w_fifo_rd;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // full is sampled before any pop on the same edge, so a write into a full
  // FIFO is always dropped even if a slot frees up at that edge.
  assign w_push    = w_data_wr && !w_full;
  assign w_fifo_rd = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_data_wr && w_full) begin
        r_overflow <= 1'b1;
      end else if (w_stat_wr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage has no reset: contents are only meaningful between the pointers.
  always_ff @(posedge Clk) begin
    if (w_push && Reset) begin
      r_mem[r_wptr[AW-1:0]] <= Dout[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_tx;
  logic          w_tx_next;
  logic          w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);

`ifdef MU0_UART_TX_PARITY_EN
  // Parity is captured when the byte is popped, since the shift register
  // consumes the data bits while they are sent.
  logic r_parity;
  logic w_parity_next;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef MU0_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_baud   <= w_baud_next;
      r_bit    <= w_bit_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
`ifdef MU0_UART_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  // Tx is registered, so the next-state logic also computes the line level
  // that belongs to the state being entered.
  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = r_baud;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_tx_next     = r_tx;
    w_pop         = 1'b0;
`ifdef MU0_UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_next  = w_fifo_rd;
          w_baud_next   = '0;
          w_state_next  = S_START;
          w_tx_next     = 1'b0;
`ifdef MU0_UART_TX_PARITY_EN
          w_parity_next = ^w_fifo_rd;
`endif
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_baud_next  = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
`ifdef MU0_UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = r_parity;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_next   = r_bit + 1'b1;
            w_shift_next = {1'b0, r_shift[7:1]};
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
`ifdef MU0_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end else begin
          w_baud_next  = r_baud + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (!w_empty) begin
            // Chain straight into the next start bit: no idle cycle.
            w_pop         = 1'b1;
            w_shift_next  = w_fifo_rd;
            w_state_next  = S_START;
            w_tx_next     = 1'b0;
`ifdef MU0_UART_TX_PARITY_EN
            w_parity_next = ^w_fifo_rd;
`endif
          end else begin
            w_state_next  = S_IDLE;
            w_tx_next     = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Tx      = r_tx;
  assign Busy    = (r_state != S_IDLE) || !w_empty;
  assign Sel     = (Addr == BASE_ADDR + 12'd1);
  assign Rd_data = {13'b0, r_overflow, Busy, w_full};

endmodule
